// File: rtl/alu_share_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational LC-3b ALU between
//               two requesters. Each operation occupies a two-cycle slot
//               (IDLE accept, EXEC), and its result lands in a per-requester
//               response buffer together with the LC-3b NZP condition codes.
//               Optional grant statistics are enabled by defining the macro
//               ALU_SHARE_STATS_EN (adds STATS_CLR, GRANT_CNT0, GRANT_CNT1).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   // requester 0
   input  logic             REQ0_VALID,
   output logic             REQ0_READY,
   input  logic [WIDTH-1:0] REQ0_A,
   input  logic [WIDTH-1:0] REQ0_B,
   input  logic [1:0]       REQ0_ALUK,
   output logic             RSP0_VALID,
   input  logic             RSP0_READY,
   output logic [WIDTH-1:0] RSP0_DATA,
   output logic [2:0]       RSP0_NZP,
   // requester 1
   input  logic             REQ1_VALID,
   output logic             REQ1_READY,
   input  logic [WIDTH-1:0] REQ1_A,
   input  logic [WIDTH-1:0] REQ1_B,
   input  logic [1:0]       REQ1_ALUK,
   output logic             RSP1_VALID,
   input  logic             RSP1_READY,
   output logic [WIDTH-1:0] RSP1_DATA,
   output logic [2:0]       RSP1_NZP,
   // shared ALU
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   output logic [1:0]       ALU_ALUK,
   input  logic [WIDTH-1:0] ALU_OUT,
   output logic             BUSY
`ifdef ALU_SHARE_STATS_EN
   ,
   input  logic             STATS_CLR,
   output logic [15:0]      GRANT_CNT0,
   output logic [15:0]      GRANT_CNT1
`endif
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_ptr;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [1:0]       r_op_aluk;
   logic             r_op_id;
   logic             r_rsp0_valid;
   logic             r_rsp1_valid;
   logic [WIDTH-1:0] r_rsp0_data;
   logic [WIDTH-1:0] r_rsp1_data;
   logic [2:0]       r_rsp0_nzp;
   logic [2:0]       r_rsp1_nzp;
   logic             w_elig0;
   logic             w_elig1;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_accept;
   logic             w_busy;
   logic [2:0]       w_alu_nzp;

   // LC-3b condition codes: exactly one of N, Z, P is set.
   function automatic logic [2:0] f_nzp(input logic [WIDTH-1:0] d);
      logic n;
      logic z;
      n = d[WIDTH-1];
      z = (d == '0);
      return {n, z, ~n & ~z};
   endfunction

   // A full buffer blocks its requester even if it drains this cycle (no bypass).
   assign w_elig0   = REQ0_VALID & ~r_rsp0_valid;
   assign w_elig1   = REQ1_VALID & ~r_rsp1_valid;
   assign w_accept  = w_grant0 | w_grant1;
   assign w_busy    = (r_state == S_EXEC);
   assign w_alu_nzp = f_nzp(ALU_OUT);

   // Round-robin grant in IDLE and the two-state slot sequencing.
   always_comb begin
      w_state_nxt = r_state;
      w_grant0    = 1'b0;
      w_grant1    = 1'b0;
      if (r_state == S_IDLE) begin
         if (w_elig0 && w_elig1) begin
            w_grant0 = ~r_ptr;
            w_grant1 = r_ptr;
         end else begin
            w_grant0 = w_elig0;
            w_grant1 = w_elig1;
         end
         if (w_grant0 || w_grant1) begin
            w_state_nxt = S_EXEC;
         end
      end else begin
         w_state_nxt = S_IDLE;
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Capture the winning operation and hand priority to the other requester.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_ptr     <= 1'b0;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_op_aluk <= 2'b00;
         r_op_id   <= 1'b0;
      end else if (w_accept) begin
         r_op_a    <= w_grant1 ? REQ1_A    : REQ0_A;
         r_op_b    <= w_grant1 ? REQ1_B    : REQ0_B;
         r_op_aluk <= w_grant1 ? REQ1_ALUK : REQ0_ALUK;
         r_op_id   <= w_grant1;
         r_ptr     <= ~w_grant1;
      end
   end

   // Response buffer 0: drain on RSP0_READY, fill at the end of its EXEC slot.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_rsp0_valid <= 1'b0;
         r_rsp0_data  <= '0;
         r_rsp0_nzp   <= 3'b000;
      end else begin
         if (r_rsp0_valid && RSP0_READY) begin
            r_rsp0_valid <= 1'b0;
         end
         if (w_busy && !r_op_id) begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_data  <= ALU_OUT;
            r_rsp0_nzp   <= w_alu_nzp;
         end
      end
   end

   // Response buffer 1: drain on RSP1_READY, fill at the end of its EXEC slot.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_rsp1_valid <= 1'b0;
         r_rsp1_data  <= '0;
         r_rsp1_nzp   <= 3'b000;
      end else begin
         if (r_rsp1_valid && RSP1_READY) begin
            r_rsp1_valid <= 1'b0;
         end
         if (w_busy && r_op_id) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_data  <= ALU_OUT;
            r_rsp1_nzp   <= w_alu_nzp;
         end
      end
   end

`ifdef ALU_SHARE_STATS_EN
   logic [15:0] r_grant_cnt0;
   logic [15:0] r_grant_cnt1;

   // Saturating grant counters; clear wins over increment.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_grant_cnt0 <= 16'h0000;
         r_grant_cnt1 <= 16'h0000;
      end else if (STATS_CLR) begin
         r_grant_cnt0 <= 16'h0000;
         r_grant_cnt1 <= 16'h0000;
      end else begin
         if (w_grant0 && !(&r_grant_cnt0)) begin
            r_grant_cnt0 <= r_grant_cnt0 + 16'h0001;
         end
         if (w_grant1 && !(&r_grant_cnt1)) begin
            r_grant_cnt1 <= r_grant_cnt1 + 16'h0001;
         end
      end
   end

   assign GRANT_CNT0 = r_grant_cnt0;
   assign GRANT_CNT1 = r_grant_cnt1;
`endif

   // Ready is held low while reset is asserted so no handshake is seen then.
   assign REQ0_READY = w_grant0 & RESET_N;
   assign REQ1_READY = w_grant1 & RESET_N;

   assign RSP0_VALID = r_rsp0_valid;
   assign RSP0_DATA  = r_rsp0_data;
   assign RSP0_NZP   = r_rsp0_nzp;
   assign RSP1_VALID = r_rsp1_valid;
   assign RSP1_DATA  = r_rsp1_data;
   assign RSP1_NZP   = r_rsp1_nzp;

   // ALU inputs are only presented during the EXEC slot.
   assign ALU_A    = w_busy ? r_op_a    : '0;
   assign ALU_B    = w_busy ? r_op_b    : '0;
   assign ALU_ALUK = w_busy ? r_op_aluk : 2'b00;
   assign BUSY     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter: a table of LC-3b
//               operations with known results, hand sequences for contention,
//               backpressure and mid-operation reset, and randomized traffic
//               against a slot-level reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_alu_share_arbiter;

   logic        CLK;
   logic        RESET_N;
   logic        REQ0_VALID, REQ0_READY, RSP0_VALID, RSP0_READY;
   logic [15:0] REQ0_A, REQ0_B, RSP0_DATA;
   logic [1:0]  REQ0_ALUK;
   logic [2:0]  RSP0_NZP;
   logic        REQ1_VALID, REQ1_READY, RSP1_VALID, RSP1_READY;
   logic [15:0] REQ1_A, REQ1_B, RSP1_DATA;
   logic [1:0]  REQ1_ALUK;
   logic [2:0]  RSP1_NZP;
   logic [15:0] ALU_A, ALU_B, ALU_OUT;
   logic [1:0]  ALU_ALUK;
   logic        BUSY;
`ifdef ALU_SHARE_STATS_EN
   logic        STATS_CLR;
   logic [15:0] GRANT_CNT0, GRANT_CNT1;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   alu_share_arbiter #(.WIDTH(16)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A),
      .REQ0_B(REQ0_B), .REQ0_ALUK(REQ0_ALUK), .RSP0_VALID(RSP0_VALID),
      .RSP0_READY(RSP0_READY), .RSP0_DATA(RSP0_DATA), .RSP0_NZP(RSP0_NZP),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A),
      .REQ1_B(REQ1_B), .REQ1_ALUK(REQ1_ALUK), .RSP1_VALID(RSP1_VALID),
      .RSP1_READY(RSP1_READY), .RSP1_DATA(RSP1_DATA), .RSP1_NZP(RSP1_NZP),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_ALUK(ALU_ALUK), .ALU_OUT(ALU_OUT),
      .BUSY(BUSY)
`ifdef ALU_SHARE_STATS_EN
      , .STATS_CLR(STATS_CLR), .GRANT_CNT0(GRANT_CNT0), .GRANT_CNT1(GRANT_CNT1)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // LC-3b ALU semantics, used both as the external ALU and by the model.
   function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] k);
      case (k)
         2'b00:   return a + b;
         2'b01:   return a & b;
         2'b10:   return a ^ b;
         default: return a;
      endcase
   endfunction

   function automatic logic [2:0] ref_nzp(input logic [15:0] d);
      if (d[15])       return 3'b100;
      else if (d == 0) return 3'b010;
      else             return 3'b001;
   endfunction

   // External combinational ALU.
   always_comb ALU_OUT = ref_alu(ALU_A, ALU_B, ALU_ALUK);

   // Reference model: one op in flight at most, two response slots, a pointer.
   bit          m_busy, m_ptr, m_win;
   logic [15:0] m_a, m_b;
   logic [1:0]  m_k;
   bit          m_rv[2];
   logic [15:0] m_rd[2];
   logic [2:0]  m_nz[2];
   int          m_cnt[2];
   bit          last_g0, last_g1;

   task automatic model_reset();
      m_busy = 0; m_ptr = 0; m_win = 0; m_a = 0; m_b = 0; m_k = 0;
      for (int i = 0; i < 2; i++) begin
         m_rv[i] = 0; m_rd[i] = 0; m_nz[i] = 0; m_cnt[i] = 0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: compare everything against the model mid-cycle, then advance it.
   // Entered and left at posedge+1, where the caller sets inputs.
   task automatic cycle();
      bit e0, e1, g0, g1;
      #1;
      e0 = !m_busy && REQ0_VALID && !m_rv[0];
      e1 = !m_busy && REQ1_VALID && !m_rv[1];
      g0 = e0 && (!e1 || !m_ptr);
      g1 = e1 && (!e0 || m_ptr);
      chk("req0_ready", REQ0_READY, g0);
      chk("req1_ready", REQ1_READY, g1);
      chk("busy", BUSY, m_busy);
      chk("rsp0_valid", RSP0_VALID, m_rv[0]);
      chk("rsp1_valid", RSP1_VALID, m_rv[1]);
      chk("rsp0_data", RSP0_DATA, m_rd[0]);
      chk("rsp1_data", RSP1_DATA, m_rd[1]);
      chk("rsp0_nzp", RSP0_NZP, m_nz[0]);
      chk("rsp1_nzp", RSP1_NZP, m_nz[1]);
      chk("alu_a", ALU_A, m_busy ? m_a : 16'h0);
      chk("alu_b", ALU_B, m_busy ? m_b : 16'h0);
      chk("alu_aluk", ALU_ALUK, m_busy ? m_k : 2'b00);
`ifdef ALU_SHARE_STATS_EN
      chk("grant_cnt0", GRANT_CNT0, m_cnt[0]);
      chk("grant_cnt1", GRANT_CNT1, m_cnt[1]);
`endif
      last_g0 = g0;
      last_g1 = g1;
      @(posedge CLK);
      if (RSP0_READY) m_rv[0] = 0;
      if (RSP1_READY) m_rv[1] = 0;
      if (m_busy) begin
         m_rv[m_win] = 1;
         m_rd[m_win] = ref_alu(m_a, m_b, m_k);
         m_nz[m_win] = ref_nzp(m_rd[m_win]);
         m_busy = 0;
      end else if (g0 || g1) begin
         m_busy = 1;
         m_win  = g1;
         m_a    = g1 ? REQ1_A : REQ0_A;
         m_b    = g1 ? REQ1_B : REQ0_B;
         m_k    = g1 ? REQ1_ALUK : REQ0_ALUK;
         m_ptr  = !g1;
      end
`ifdef ALU_SHARE_STATS_EN
      if (STATS_CLR) begin
         m_cnt[0] = 0; m_cnt[1] = 0;
      end else begin
         if (g0 && m_cnt[0] < 65535) m_cnt[0]++;
         if (g1 && m_cnt[1] < 65535) m_cnt[1]++;
      end
`endif
      #1;
   endtask

   task automatic drive_idle();
      REQ0_VALID = 0; REQ0_A = 0; REQ0_B = 0; REQ0_ALUK = 0;
      REQ1_VALID = 0; REQ1_A = 0; REQ1_B = 0; REQ1_ALUK = 0;
      RSP0_READY = 0; RSP1_READY = 0;
`ifdef ALU_SHARE_STATS_EN
      STATS_CLR = 0;
`endif
   endtask

   task automatic set_req(input bit id, input bit v, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] k);
      if (id) begin
         REQ1_VALID = v; REQ1_A = a; REQ1_B = b; REQ1_ALUK = k;
      end else begin
         REQ0_VALID = v; REQ0_A = a; REQ0_B = b; REQ0_ALUK = k;
      end
   endtask

   // Reset pulse with reset-value checks; returns at posedge+1 with reset released.
   task automatic do_reset();
      RESET_N = 0;
      model_reset();
      repeat (2) @(posedge CLK);
      #2;
      chk("rst_busy", BUSY, 0);
      chk("rst_req0_ready", REQ0_READY, 0);
      chk("rst_req1_ready", REQ1_READY, 0);
      chk("rst_rsp_valid", {RSP0_VALID, RSP1_VALID}, 0);
      chk("rst_rsp_data", {RSP0_DATA, RSP1_DATA}, 0);
      chk("rst_rsp_nzp", {RSP0_NZP, RSP1_NZP}, 0);
      chk("rst_alu", {ALU_A, ALU_B, ALU_ALUK}, 0);
      @(posedge CLK);
      #1;
      RESET_N = 1;
   endtask

   typedef struct {
      bit          id;
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  k;
      logic [15:0] exp_d;
      logic [2:0]  exp_nzp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int cnt_g0, cnt_g1;
      bit got;

      vecs[0] = '{1'b0, 16'h0005, 16'h0003, 2'b00, 16'h0008, 3'b001};
      vecs[1] = '{1'b1, 16'hFFFF, 16'h8000, 2'b01, 16'h8000, 3'b100};
      vecs[2] = '{1'b0, 16'h1234, 16'h1234, 2'b10, 16'h0000, 3'b010};
      vecs[3] = '{1'b1, 16'h7FFF, 16'hABCD, 2'b11, 16'h7FFF, 3'b001};
      vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 3'b010};

      drive_idle();
      do_reset();

      // Table: single operations, latency and drain.
      for (int i = 0; i < 5; i++) begin
         set_req(vecs[i].id, 1, vecs[i].a, vecs[i].b, vecs[i].k);
         cycle();
         chk($sformatf("v%0d_accept", i), vecs[i].id ? last_g1 : last_g0, 1);
         set_req(vecs[i].id, 0, 16'h0, 16'h0, 2'b00);
         chk($sformatf("v%0d_not_yet", i), vecs[i].id ? RSP1_VALID : RSP0_VALID, 0);
         cycle();
         chk($sformatf("v%0d_valid", i), vecs[i].id ? RSP1_VALID : RSP0_VALID, 1);
         chk($sformatf("v%0d_data", i), vecs[i].id ? RSP1_DATA : RSP0_DATA, vecs[i].exp_d);
         chk($sformatf("v%0d_nzp", i), vecs[i].id ? RSP1_NZP : RSP0_NZP, vecs[i].exp_nzp);
         if (vecs[i].id) RSP1_READY = 1; else RSP0_READY = 1;
         cycle();
         chk($sformatf("v%0d_drained", i), vecs[i].id ? RSP1_VALID : RSP0_VALID, 0);
         RSP0_READY = 0; RSP1_READY = 0;
      end

      // Contention straight out of reset: grants 0,1,0,1,0 and BUSY toggling.
      drive_idle();
      do_reset();
      RSP0_READY = 1; RSP1_READY = 1;
      for (int i = 0; i < 10; i++) begin
         set_req(0, 1, 16'h0100 + 16'(i), 16'h0011, 2'b00);
         set_req(1, 1, 16'h0F0F, 16'h00FF + 16'(i), 2'b10);
         cycle();
         chk($sformatf("cont_g0_%0d", i), last_g0, (i % 4) == 0);
         chk($sformatf("cont_g1_%0d", i), last_g1, (i % 4) == 2);
         chk($sformatf("cont_busy_%0d", i), BUSY, (i % 2) == 0);
      end
      set_req(0, 0, 16'h0, 16'h0, 2'b00);
      set_req(1, 0, 16'h0, 16'h0, 2'b00);
`ifdef ALU_SHARE_STATS_EN
      cycle();
      chk("stats_cnt0", GRANT_CNT0, 3);
      chk("stats_cnt1", GRANT_CNT1, 2);
      STATS_CLR = 1;
      cycle();
      STATS_CLR = 0;
      chk("stats_clr", {GRANT_CNT0, GRANT_CNT1}, 0);
`endif
      repeat (2) cycle();

      // Backpressure on requester 1 while requester 0 keeps being served.
      drive_idle();
      do_reset();
      set_req(1, 1, 16'h0002, 16'h0003, 2'b00);
      cycle();
      cycle();
      chk("bp_rsp1_full", RSP1_VALID, 1);
      RSP0_READY = 1;
      set_req(0, 1, 16'h4000, 16'h0001, 2'b00);
      cnt_g0 = 0; cnt_g1 = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (last_g0) cnt_g0++;
         if (last_g1) cnt_g1++;
      end
      chk("bp_req1_blocked", cnt_g1, 0);
      chk("bp_req0_served", cnt_g0 >= 2, 1);
      RSP1_READY = 1;
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         cycle();
         if (last_g1) got = 1;
      end
      chk("bp_req1_resumed", got, 1);
      set_req(0, 0, 16'h0, 16'h0, 2'b00);
      set_req(1, 0, 16'h0, 16'h0, 2'b00);
      repeat (3) cycle();

      // Reset during EXEC discards the operation.
      set_req(0, 1, 16'h1111, 16'h2222, 2'b00);
      RSP0_READY = 0;
      cycle();
      chk("mid_accept", last_g0, 1);
      set_req(0, 0, 16'h0, 16'h0, 2'b00);
      chk("mid_busy", BUSY, 1);
      set_req(1, 1, 16'h0001, 16'h0001, 2'b00);
      #1;
      RESET_N = 0;
      #1;
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_ready", {REQ0_READY, REQ1_READY}, 0);
      chk("mid_rst_rsp", {RSP0_VALID, RSP1_VALID, RSP0_DATA, RSP1_DATA, RSP0_NZP, RSP1_NZP}, 0);
      chk("mid_rst_alu", {ALU_A, ALU_B, ALU_ALUK}, 0);
      model_reset();
      set_req(1, 0, 16'h0, 16'h0, 2'b00);
      @(posedge CLK);
      #1;
      RESET_N = 1;
      repeat (4) cycle();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         set_req(0, ($urandom_range(9) < 6), 16'($urandom), 16'($urandom), 2'($urandom));
         set_req(1, ($urandom_range(9) < 6), 16'($urandom), 16'($urandom), 2'($urandom));
         RSP0_READY = ($urandom_range(3) != 0);
         RSP1_READY = ($urandom_range(3) != 0);
`ifdef ALU_SHARE_STATS_EN
         STATS_CLR = ($urandom_range(63) == 0);
`endif
         cycle();
      end
      drive_idle();
      repeat (3) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
